// File: rtl/gpr_wport_arb.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wport_arb
// Description : Round-robin arbiter for the single GPR write port shared by
//               the ALU, load and flag requesters. The winner is registered
//               onto the register-file write port one cycle after its grant.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wport_arb #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,     // asynchronous, active-low
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  output logic [2:0]    gnt,
  output logic          gpr_wr,
  output logic [AW-1:0] gpr_wa,
  output logic [DW-1:0] gpr_wd,
  output logic          busy,
  output logic [CW-1:0] wr_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [1:0]    ptr;
  logic [1:0]    ptr_eff;
  logic [1:0]    cand0;
  logic [1:0]    cand1;
  logic [1:0]    cand2;
  logic [1:0]    win;
  logic          win_vld;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          commit;
  logic          multi_req;

  // Search order starting at the pointer; an illegal pointer of 3 acts as 0.
  always_comb begin
    ptr_eff = (ptr == 2'd3) ? 2'd0 : ptr;
    cand0   = ptr_eff;
    cand1   = (ptr_eff == 2'd2) ? 2'd0 : 2'(ptr_eff + 2'd1);
    cand2   = (ptr_eff == 2'd0) ? 2'd2 : 2'(ptr_eff - 2'd1);
  end

  // Pick the first requester in search order; grants are suppressed in reset.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    gnt     = 3'b000;
    if (rst) begin
      if (req[cand0]) begin
        win     = cand0;
        win_vld = 1'b1;
      end else if (req[cand1]) begin
        win     = cand1;
        win_vld = 1'b1;
      end else if (req[cand2]) begin
        win     = cand2;
        win_vld = 1'b1;
      end
      if (win_vld) begin
        gnt[win] = 1'b1;
      end
    end
  end

  // Route the winner's address and data toward the output register.
  always_comb begin
    win_addr = addr0;
    win_data = data0;
    case (win)
      2'd1: begin
        win_addr = addr1;
        win_data = data1;
      end
      2'd2: begin
        win_addr = addr2;
        win_data = data2;
      end
      default: begin
        win_addr = addr0;
        win_data = data0;
      end
    endcase
  end

  // Writes to r0 are accepted (releasing the requester) but never committed.
  always_comb begin
    commit    = win_vld && (win_addr != '0);
    multi_req = ({1'b0, req[0]} + {1'b0, req[1]} + {1'b0, req[2]}) >= 2'd2;
  end

  // Pointer, output port register, busy flag and saturating write counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= 2'd0;
      gpr_wr <= 1'b0;
      gpr_wa <= '0;
      gpr_wd <= '0;
      busy   <= 1'b0;
      wr_cnt <= '0;
    end else begin
      if (win_vld) begin
        ptr    <= (win == 2'd2) ? 2'd0 : 2'(win + 2'd1);
        gpr_wa <= win_addr;
        gpr_wd <= win_data;
      end
      gpr_wr <= commit;
      busy   <= multi_req;
      if (commit && (wr_cnt != CNT_MAX)) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
